// File: rtl/step_sequencer_if.sv
// Pass-control bundle between the elimination sequencer (master) and the systolic line (slave).
// Widths are derived from the same N/L/K parameters the sequencer is built with.
interface step_sequencer_if #(
    parameter int N = 4,
    parameter int L = 8,
    parameter int K = 16
);
    localparam int NB     = K / N;
    localparam int CB_W   = $clog2(NB + 1);
    localparam int ROWS_W = $clog2(L * K / N + 2 * N + 1);

    logic              step_start;
    logic              step_functionA;
    logic              step_last_phase;
    logic [CB_W-1:0]   step_col_block;
    logic [ROWS_W-1:0] step_first_pass_rows;
    logic              step_done;
    logic              step_fail;

    modport master (
        output step_start,
        output step_functionA,
        output step_last_phase,
        output step_col_block,
        output step_first_pass_rows,
        input  step_done,
        input  step_fail
    );

    modport slave (
        input  step_start,
        input  step_functionA,
        input  step_last_phase,
        input  step_col_block,
        input  step_first_pass_rows,
        output step_done,
        output step_fail
    );
endinterface

// File: rtl/step_sequencer.sv
// Sequences pivot (A) and apply (B) passes of a blocked elimination over a systolic line,
// with a per-pass watchdog and sticky failure-cause flags.
module step_sequencer #(
    parameter int N       = 4,
    parameter int L       = 8,
    parameter int K       = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic busy,
    output logic done,
    output logic fail,
    output logic timeout,
    output logic singular,
    output logic [$clog2((L + N - 1) / N + 1)-1:0] phase,
    step_sequencer_if.master step
);
    localparam int NB     = K / N;
    localparam int P      = (L + N - 1) / N;
    localparam int PH_W   = $clog2(P + 1);
    localparam int CB_W   = $clog2(NB + 1);
    localparam int ROWS_W = $clog2(L * K / N + 2 * N + 1);
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_A,
        WAIT_A,
        ISSUE_B,
        WAIT_B,
        NEXT,
        DONE,
        FAIL
    } state_t;

    typedef struct packed {
        logic              fa;
        logic              lp;
        logic [CB_W-1:0]   cb;
        logic [ROWS_W-1:0] rows;
    } pass_t;

    // Descriptor presented to the line for one pass; all fields held for the whole pass.
    function automatic pass_t pass_cfg(input logic fa, input logic [CB_W-1:0] cb,
                                       input logic [PH_W-1:0] ph);
        pass_t c;
        c.fa   = fa;
        c.lp   = (ph == PH_W'(P - 1));
        c.cb   = cb;
        c.rows = ROWS_W'(cb) * ROWS_W'(L) + ROWS_W'(N);
        return c;
    endfunction

    state_t            r_state;
    logic [PH_W-1:0]   r_phase;
    logic [CB_W-1:0]   r_cb;
    logic [WD_W-1:0]   r_wd;
    logic              r_busy;
    logic              r_done;
    logic              r_fail;
    logic              r_timeout;
    logic              r_singular;
    logic              r_start;
    pass_t             r_pass;

    logic [WD_W-1:0]   w_wd_inc;
    logic              w_wd_expired;
    logic [CB_W-1:0]   w_cb_a;
    logic              w_a_has_b;
    logic [CB_W-1:0]   w_cb_b;
    logic              w_b_more;
    logic              w_ph_last;
    logic [PH_W-1:0]   w_ph_inc;

    assign w_wd_inc     = r_wd + WD_W'(1);
    assign w_wd_expired = (w_wd_inc >= WD_W'(TIMEOUT - 1));
    assign w_cb_a       = CB_W'(r_phase) + CB_W'(1);
    assign w_a_has_b    = (w_cb_a <= CB_W'(NB - 1));
    assign w_cb_b       = r_cb + CB_W'(1);
    assign w_b_more     = (r_cb < CB_W'(NB - 1));
    assign w_ph_last    = (r_phase == PH_W'(P - 1));
    assign w_ph_inc     = r_phase + PH_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_phase    <= '0;
            r_cb       <= '0;
            r_wd       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fail     <= 1'b0;
            r_timeout  <= 1'b0;
            r_singular <= 1'b0;
            r_start    <= 1'b0;
            r_pass     <= '0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (go) begin
                        r_state    <= ISSUE_A;
                        r_phase    <= '0;
                        r_cb       <= '0;
                        r_timeout  <= 1'b0;
                        r_singular <= 1'b0;
                        r_busy     <= 1'b1;
                        r_start    <= 1'b1;
                        r_pass     <= pass_cfg(1'b1, '0, '0);
                    end
                end
                ISSUE_A: begin
                    r_wd    <= '0;
                    r_state <= WAIT_A;
                end
                WAIT_A: begin
                    // A returning step_done beats a watchdog expiring in the same cycle.
                    if (step.step_done) begin
                        if (step.step_fail) begin
                            r_state    <= FAIL;
                            r_fail     <= 1'b1;
                            r_singular <= 1'b1;
                            r_pass     <= '0;
                        end else if (w_a_has_b) begin
                            r_state <= ISSUE_B;
                            r_cb    <= w_cb_a;
                            r_start <= 1'b1;
                            r_pass  <= pass_cfg(1'b0, w_cb_a, r_phase);
                        end else begin
                            r_state <= NEXT;
                            r_pass  <= '0;
                        end
                    end else if (w_wd_expired) begin
                        r_state   <= FAIL;
                        r_fail    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_pass    <= '0;
                    end else begin
                        r_wd <= w_wd_inc;
                    end
                end
                ISSUE_B: begin
                    r_wd    <= '0;
                    r_state <= WAIT_B;
                end
                WAIT_B: begin
                    if (step.step_done) begin
                        if (w_b_more) begin
                            r_state <= ISSUE_B;
                            r_cb    <= w_cb_b;
                            r_start <= 1'b1;
                            r_pass  <= pass_cfg(1'b0, w_cb_b, r_phase);
                        end else begin
                            r_state <= NEXT;
                            r_pass  <= '0;
                        end
                    end else if (w_wd_expired) begin
                        r_state   <= FAIL;
                        r_fail    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_pass    <= '0;
                    end else begin
                        r_wd <= w_wd_inc;
                    end
                end
                NEXT: begin
                    if (w_ph_last) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ISSUE_A;
                        r_phase <= w_ph_inc;
                        r_start <= 1'b1;
                        r_pass  <= pass_cfg(1'b1, CB_W'(w_ph_inc), w_ph_inc);
                    end
                end
                DONE, FAIL: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_pass  <= '0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign fail     = r_fail;
    assign timeout  = r_timeout;
    assign singular = r_singular;
    assign phase    = r_phase;

    assign step.step_start           = r_start;
    assign step.step_functionA       = r_pass.fa;
    assign step.step_last_phase      = r_pass.lp;
    assign step.step_col_block       = r_pass.cb;
    assign step.step_first_pass_rows = r_pass.rows;
endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: pass order/descriptors, pulse timing, failure causes and reset.
module tb_step_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, go0, go1, go2;
    logic busy0, done0, fail0, to0, sing0;
    logic busy1, done1, fail1, to1, sing1;
    logic busy2, done2, fail2, to2, sing2;
    logic [1:0] ph0, ph1;
    logic [2:0] ph2;

    step_sequencer_if #(.N(4), .L(8),  .K(16)) s0 ();
    step_sequencer_if #(.N(4), .L(8),  .K(16)) s1 ();
    step_sequencer_if #(.N(4), .L(16), .K(16)) s2 ();

    step_sequencer #(.N(4), .L(8), .K(16), .TIMEOUT(1024)) dut0 (
        .clk(clk), .rst(rst), .go(go0), .busy(busy0), .done(done0), .fail(fail0),
        .timeout(to0), .singular(sing0), .phase(ph0), .step(s0));
    step_sequencer #(.N(4), .L(8), .K(16), .TIMEOUT(16)) dut1 (
        .clk(clk), .rst(rst), .go(go1), .busy(busy1), .done(done1), .fail(fail1),
        .timeout(to1), .singular(sing1), .phase(ph1), .step(s1));
    step_sequencer #(.N(4), .L(16), .K(16), .TIMEOUT(1024)) dut2 (
        .clk(clk), .rst(rst), .go(go2), .busy(busy2), .done(done2), .fail(fail2),
        .timeout(to2), .singular(sing2), .phase(ph2), .step(s2));

    typedef struct {int fa; int cb; int lp; int rows;} vec_t;
    typedef struct {int fa; int cb; int lp; int rows; int cyc;} rec_t;

    vec_t exp0[7];
    vec_t exp2[10];
    rec_t log0[$];
    rec_t log2[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line model for dut0: step_done 20 cycles after each step_start, optional pivot failure.
    int cnt0 = 0, a_idx0 = -1, done_n0 = 0, fail_n0 = 0, done_cyc0 = 0, fail_cyc0 = 0;
    int fail_a_abs = -100;
    bit cur_a0 = 1'b0, inj0 = 1'b0;
    always @(negedge clk) begin
        s0.step_done = inj0;
        s0.step_fail = 1'b0;
        if (rst) cnt0 = 0;
        else if (cnt0 > 0) begin
            cnt0--;
            if (cnt0 == 0) begin
                s0.step_done = 1'b1;
                s0.step_fail = (cur_a0 && a_idx0 == fail_a_abs);
            end
        end
        if (s0.step_start) begin
            log0.push_back('{int'(s0.step_functionA), int'(s0.step_col_block),
                             int'(s0.step_last_phase), int'(s0.step_first_pass_rows), cyc});
            cnt0   = 20;
            cur_a0 = s0.step_functionA;
            if (cur_a0) a_idx0++;
        end
        if (done0) begin done_n0++; done_cyc0 = cyc; end
        if (fail0) begin fail_n0++; fail_cyc0 = cyc; end
    end

    // dut1 never gets step_done back.
    assign s1.step_done = 1'b0;
    assign s1.step_fail = 1'b0;
    int first1 = -1, fail_n1 = 0, fail_cyc1 = 0;
    always @(negedge clk) begin
        if (s1.step_start && first1 < 0) first1 = cyc;
        if (fail1) begin fail_n1++; fail_cyc1 = cyc; end
    end

    // Line model for dut2: step_done 5 cycles after each step_start.
    int cnt2 = 0, done_n2 = 0, fail_n2 = 0, done_cyc2 = 0;
    always @(negedge clk) begin
        s2.step_done = 1'b0;
        s2.step_fail = 1'b0;
        if (rst) cnt2 = 0;
        else if (cnt2 > 0) begin
            cnt2--;
            if (cnt2 == 0) s2.step_done = 1'b1;
        end
        if (s2.step_start) begin
            log2.push_back('{int'(s2.step_functionA), int'(s2.step_col_block),
                             int'(s2.step_last_phase), int'(s2.step_first_pass_rows), cyc});
            cnt2 = 5;
        end
        if (done2) begin done_n2++; done_cyc2 = cyc; end
        if (fail2) fail_n2++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_go(input int which);
        case (which)
            0:       go0 = 1'b1;
            1:       go1 = 1'b1;
            default: go2 = 1'b1;
        endcase
        tick();
        go0 = 1'b0;
        go1 = 1'b0;
        go2 = 1'b0;
    endtask

    task automatic wait_end0(input int db, input int fb, input string name);
        for (int i = 0; i < 400; i++) begin
            if (done_n0 > db || fail_n0 > fb) break;
            tick();
        end
        check(name, (done_n0 - db) + (fail_n0 - fb), 1);
    endtask

    task automatic check_default_run(input int lb, input int db, input int fb, input string tag);
        check({tag, " pass count"}, log0.size() - lb, 7);
        for (int i = 0; i < 7; i++) begin
            if (lb + i < log0.size()) begin
                check($sformatf("%s pass%0d fa", tag, i),   log0[lb+i].fa,   exp0[i].fa);
                check($sformatf("%s pass%0d cb", tag, i),   log0[lb+i].cb,   exp0[i].cb);
                check($sformatf("%s pass%0d lp", tag, i),   log0[lb+i].lp,   exp0[i].lp);
                check($sformatf("%s pass%0d rows", tag, i), log0[lb+i].rows, exp0[i].rows);
            end
        end
        check({tag, " done pulses"}, done_n0 - db, 1);
        check({tag, " fail pulses"}, fail_n0 - fb, 0);
        if (log0.size() > lb)
            check({tag, " done latency"}, done_cyc0 - log0[lb].cyc, 149);
        check({tag, " busy after done"}, busy0, 0);
        check({tag, " col_block idle"}, s0.step_col_block, 0);
        check({tag, " rows idle"}, s0.step_first_pass_rows, 0);
        check({tag, " timeout flag"}, to0, 0);
        check({tag, " singular flag"}, sing0, 0);
    endtask

    int lb, db, fb;

    initial begin
        exp0 = '{'{1,0,0,4}, '{0,1,0,12}, '{0,2,0,20}, '{0,3,0,28},
                 '{1,1,1,12}, '{0,2,1,20}, '{0,3,1,28}};
        exp2 = '{'{1,0,0,4}, '{0,1,0,20}, '{0,2,0,36}, '{0,3,0,52},
                 '{1,1,0,20}, '{0,2,0,36}, '{0,3,0,52},
                 '{1,2,0,36}, '{0,3,0,52}, '{1,3,1,52}};

        rst = 1'b1; go0 = 1'b0; go1 = 1'b0; go2 = 1'b0;
        repeat (3) tick();
        check("rst busy",     busy0, 0);
        check("rst done",     done0, 0);
        check("rst fail",     fail0, 0);
        check("rst timeout",  to0, 0);
        check("rst singular", sing0, 0);
        check("rst phase",    ph0, 0);
        check("rst start",    s0.step_start, 0);
        check("rst rows",     s0.step_first_pass_rows, 0);
        check("rst busy2",    busy2, 0);
        rst = 1'b0;
        tick();

        // Nominal default run
        lb = log0.size(); db = done_n0; fb = fail_n0;
        pulse_go(0);
        check("go busy",  busy0, 1);
        check("go start", s0.step_start, 1);
        wait_end0(db, fb, "run1 end");
        check_default_run(lb, db, fb, "run1");

        // Pivot failure on the second A-pass
        fail_a_abs = a_idx0 + 2;
        lb = log0.size(); db = done_n0; fb = fail_n0;
        pulse_go(0);
        wait_end0(db, fb, "sing end");
        check("sing passes",   log0.size() - lb, 5);
        check("sing fail",     fail_n0 - fb, 1);
        check("sing done",     done_n0 - db, 0);
        check("sing flag",     sing0, 1);
        check("sing timeout",  to0, 0);
        check("sing busy",     busy0, 0);
        if (log0.size() > lb)
            check("sing fail latency", fail_cyc0 - log0[lb].cyc, 106);
        repeat (30) tick();
        check("sing no more starts", log0.size() - lb, 5);
        check("sing sticky", sing0, 1);
        fail_a_abs = -100;

        // Reset during the third pass
        lb = log0.size(); db = done_n0; fb = fail_n0;
        pulse_go(0);
        check("go clears singular", sing0, 0);
        for (int i = 0; i < 200 && log0.size() < lb + 3; i++) tick();
        check("third pass issued", log0.size() - lb, 3);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst busy",  busy0, 0);
        check("midrst start", s0.step_start, 0);
        check("midrst phase", ph0, 0);
        check("midrst fa",    s0.step_functionA, 0);
        check("midrst cb",    s0.step_col_block, 0);
        check("midrst rows",  s0.step_first_pass_rows, 0);
        check("midrst no done pulse", done_n0 - db, 0);
        check("midrst no fail pulse", fail_n0 - fb, 0);
        go0 = 1'b1;
        tick();
        rst = 1'b0;
        go0 = 1'b0;
        tick();
        check("go with rst ignored", busy0, 0);
        check("no start after rst", log0.size() - lb, 3);

        // step_done while idle, then a run with a stray go while busy
        inj0 = 1'b1;
        tick();
        inj0 = 1'b0;
        tick();
        check("idle step_done ignored", busy0, 0);
        lb = log0.size(); db = done_n0; fb = fail_n0;
        pulse_go(0);
        repeat (30) tick();
        pulse_go(0);
        check("busy go ignored", busy0, 1);
        wait_end0(db, fb, "run2 end");
        check_default_run(lb, db, fb, "run2");

        // Watchdog with TIMEOUT=16
        pulse_go(1);
        for (int i = 0; i < 100 && fail_n1 == 0; i++) tick();
        check("wd fail pulses", fail_n1, 1);
        check("wd fail latency", fail_cyc1 - first1, 16);
        check("wd timeout flag", to1, 1);
        check("wd singular flag", sing1, 0);
        check("wd busy", busy1, 0);
        check("wd done", done1, 0);
        check("wd phase", ph1, 0);
        check("wd fa idle", s1.step_functionA, 0);
        check("wd lp idle", s1.step_last_phase, 0);
        check("wd cb idle", s1.step_col_block, 0);
        check("wd rows idle", s1.step_first_pass_rows, 0);
        check("wd start idle", s1.step_start, 0);

        // P == NB: last phase has no B-pass
        lb = log2.size();
        pulse_go(2);
        for (int i = 0; i < 1000 && done_n2 == 0; i++) tick();
        check("pnb done pulses", done_n2, 1);
        check("pnb fail pulses", fail_n2, 0);
        check("pnb pass count", log2.size() - lb, 10);
        for (int i = 0; i < 10; i++) begin
            if (lb + i < log2.size()) begin
                check($sformatf("pnb pass%0d fa", i),   log2[lb+i].fa,   exp2[i].fa);
                check($sformatf("pnb pass%0d cb", i),   log2[lb+i].cb,   exp2[i].cb);
                check($sformatf("pnb pass%0d lp", i),   log2[lb+i].lp,   exp2[i].lp);
                check($sformatf("pnb pass%0d rows", i), log2[lb+i].rows, exp2[i].rows);
            end
        end
        if (log2.size() > 0)
            check("pnb last A to done", done_cyc2 - log2[log2.size()-1].cyc, 7);
        check("pnb phase", ph2, 3);
        check("pnb busy", busy2, 0);
        check("pnb flags", {to2, sing2}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameters SHALL be: N, default 4, architecture size; L, default 8, matrix rows; K, default 16, matrix columns; TIMEOUT, default 1024, max cycles per pass.
REQ-002 Derived constants SHALL be: NB = K/N, the column-block count; P = (L+N-1)/N, the pivot phase count. P <= NB is a legal-parameter requirement.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 go  in  1  single-cycle request to run a full elimination.
REQ-006 busy  out  1  high from the cycle after an accepted go until the DONE or FAIL state is left.
REQ-007 done  out  1  single-cycle pulse, elimination succeeded.
REQ-008 fail  out  1  single-cycle pulse, elimination aborted.
REQ-009 timeout  out  1  sticky cause flag, set with fail when the watchdog expires; cleared on accepted go or rst.
REQ-010 singular  out  1  sticky cause flag, set with fail when a pivot pass reports failure; cleared on accepted go or rst.
REQ-011 phase  out  CLOG2(P+1)  current pivot phase index.
REQ-012 step_start  out  1  pass-start pulse to the systolic line.
REQ-013 step_functionA  out  1  1 = pivot (A) pass, 0 = apply (B) pass.
REQ-014 step_last_phase  out  1  high during passes of phase P-1.
REQ-015 step_col_block  out  CLOG2(NB+1)  column block of the current pass.
REQ-016 step_first_pass_rows  out  CLOG2(L*K/N+2*N+1)  row threshold for the current pass.
REQ-017 step_done  in  1  pass-complete pulse from the systolic line.
REQ-018 step_fail  in  1  pivot failure, valid only with step_done.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE_A, WAIT_A, ISSUE_B, WAIT_B, NEXT, DONE, FAIL.
REQ-020 IDLE: go=1 SHALL transition to ISSUE_A and set phase=0, cb=0, clear timeout and singular. go in any other state SHALL be ignored.
REQ-021 ISSUE_A SHALL assert step_start for exactly 1 cycle with step_functionA=1, step_col_block=phase, then go to WAIT_A.
REQ-022 WAIT_A with step_done=1:
  - step_fail=1 -> FAIL with singular=1.
  - step_fail=0 and phase+1 <= NB-1 -> ISSUE_B with cb=phase+1.
  - step_fail=0 otherwise -> NEXT.
REQ-023 ISSUE_B SHALL assert step_start for 1 cycle with step_functionA=0, step_col_block=cb, then go to WAIT_B.
REQ-024 WAIT_B with step_done=1: if cb < NB-1, go to ISSUE_B with cb+1; else go to NEXT. step_fail SHALL be ignored in WAIT_B.
REQ-025 NEXT: if phase == P-1, go to DONE; else increment phase and go to ISSUE_A.
REQ-026 DONE SHALL pulse done for 1 cycle, then go to IDLE. FAIL SHALL pulse fail for 1 cycle, then go to IDLE.
REQ-027 step_done SHALL be sampled only in WAIT_A and WAIT_B. It SHALL be ignored in all other states, including the ISSUE cycle.
REQ-028 step_functionA, step_col_block, step_last_phase and step_first_pass_rows SHALL be registered and SHALL be stable from the ISSUE cycle through the end of the matching WAIT state.
REQ-029 step_last_phase SHALL equal (phase == P-1) in all ISSUE and WAIT states, and 0 elsewhere.
REQ-030 step_first_pass_rows SHALL equal step_col_block*L + N, computed at full output width with no truncation for legal parameters.
REQ-031 Watchdog counter, width CLOG2(TIMEOUT+1):
  - cleared in every ISSUE state;
  - increments each WAIT cycle without step_done;
  - on reaching TIMEOUT-1 without step_done -> FAIL with timeout=1;
  - if step_done arrives in that same cycle, step_done SHALL win.
REQ-032 A full run SHALL issue exactly P A-passes and the sum over p = 0..P-1 of (NB-1-p) B-passes, in strictly ascending (phase, cb) order.
REQ-033 Outside the ISSUE and WAIT states, step_start SHALL be 0 and step_functionA, step_last_phase, step_col_block, step_first_pass_rows SHALL be 0.

Reset
REQ-034 rst=1 SHALL force IDLE in the following cycle from any state, including mid-pass.
REQ-035 rst SHALL clear busy, done, fail, timeout, singular, phase, cb, the watchdog and all step_* outputs to 0, with no partial done or fail pulse.
REQ-036 A go in the same cycle as rst SHALL be ignored.

Verification
REQ-037 Defaults (N=4, L=8, K=16), go, step_done returned 20 cycles after each step_start, step_fail=0 -> 7 passes in order:
  - (A,0,lp0), (B,1,lp0), (B,2,lp0), (B,3,lp0), (A,1,lp1), (B,2,lp1), (B,3,lp1);
  - first_pass_rows 4, 12, 20, 28, 12, 20, 28;
  - one done pulse, busy then falls.
REQ-038 Defaults, step_fail=1 with the second A-pass step_done -> fail pulse, singular=1, timeout=0, no further step_start.
REQ-039 TIMEOUT=16, step_done never returned -> fail pulse 16 cycles after the first step_start, timeout=1.
REQ-040 N=4, L=16, K=16 (P=NB=4) -> the phase-3 A-pass is followed directly by done with no B-pass; 10 passes total.
REQ-041 rst asserted during the third pass, then go -> step_start=0 and busy=0 one cycle after rst; the new run restarts at (A,0) with timeout and singular cleared.
REQ-042 go pulsed while busy, and step_done pulsed while in IDLE -> both ignored; pass sequence and counts unchanged.
